// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and shared RAM port.
// The master modport is the arbiter's view; slave is the view of the
// surrounding pipeline and RAM.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and
// data access. Data has fixed priority over fetch; one transaction at a time
// through IDLE -> ACCESS -> (WAIT) -> DONE. All bus outputs are registered
// except the stalls, which are derived from the registered ready pulses.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add the 32-bit stall
// counters perf_if_stall / perf_mem_stall.
module mem_port_arbiter #(
  parameter int RAM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_mem_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // Cycles spent in WAIT beyond the first, loaded on leaving ACCESS.
  localparam logic [2:0] WAIT_INIT = 3'((RAM_LAT > 1) ? (RAM_LAT - 2) : 0);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;     // 1 = data port, 0 = fetch port
  logic        wr_q, wr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic        stall_if_w, stall_mem_w;

  assign stall_if_w  = bus.if_req & ~if_ready_q;
  assign stall_mem_w = (bus.mem_read | bus.mem_write) & ~mem_ready_q;

  assign bus.stall_if  = stall_if_w;
  assign bus.stall_mem = stall_mem_w;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;

  // Next-state and registered-output decode for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_read | bus.mem_write) begin
          // Read and write together resolve to a write.
          owner_d     = 1'b1;
          wr_d        = bus.mem_write;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_write;
          state_d     = ACCESS;
        end else if (bus.if_req) begin
          owner_d     = 1'b0;
          wr_d        = 1'b0;
          ram_addr_d  = bus.if_addr;
          ram_wdata_d = 32'd0;
          ram_en_d    = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q || RAM_LAT == 1) begin
          if (!wr_q) begin
            if (owner_q) mem_rdata_d = bus.ram_rdata;
            else         if_rdata_d  = bus.ram_rdata;
          end
          mem_ready_d = owner_q;
          if_ready_d  = ~owner_q;
          state_d     = DONE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (owner_q) mem_rdata_d = bus.ram_rdata;
          else         if_rdata_d  = bus.ram_rdata;
          mem_ready_d = owner_q;
          if_ready_d  = ~owner_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        // Ready pulse is visible this cycle; never grant from here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 3'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_mem_q;

  // Free-running stall counters, one increment per stalled cycle, wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_q  <= 32'd0;
      perf_mem_q <= 32'd0;
    end else begin
      perf_if_q  <= perf_if_q  + {31'd0, stall_if_w};
      perf_mem_q <= perf_mem_q + {31'd0, stall_mem_w};
    end
  end

  assign perf_if_stall  = perf_if_q;
  assign perf_mem_stall = perf_mem_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RAM_LAT=2 and one
// with RAM_LAT=1, each fed by a small RAM model honouring that latency.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pa_if, pa_mem, pb_if, pb_mem;
  mem_port_arbiter #(.RAM_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa),
                                         .perf_if_stall(pa_if), .perf_mem_stall(pa_mem));
  mem_port_arbiter #(.RAM_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb),
                                         .perf_if_stall(pb_if), .perf_mem_stall(pb_mem));
`else
  mem_port_arbiter #(.RAM_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_port_arbiter #(.RAM_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
`endif

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: ram_val = 32'h1234_5678;
      32'h0000_0000: ram_val = 32'h0000_0013;
      default:       ram_val = {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // RAM_LAT=2 model: data appears one register after the enable cycle.
  logic [31:0] pipe_a;
  always @(posedge clk)
    pipe_a <= (ifa.ram_en && !ifa.ram_we) ? ram_val(ifa.ram_addr) : 32'hBAD0_BAD0;
  assign ifa.ram_rdata = pipe_a;
  // RAM_LAT=1 model: data valid during the enable cycle only.
  assign ifb.ram_rdata = (ifb.ram_en && !ifb.ram_we) ? ram_val(ifb.ram_addr) : 32'hBAD0_BAD0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    ifa.if_req = 0; ifa.if_addr = 0; ifa.mem_read = 0; ifa.mem_write = 0;
    ifa.mem_addr = 0; ifa.mem_wdata = 0;
    ifb.if_req = 0; ifb.if_addr = 0; ifb.mem_read = 0; ifb.mem_write = 0;
    ifb.mem_addr = 0; ifb.mem_wdata = 0;
    repeat (3) tick();
    chk("rst_ram_en", ifa.ram_en, 0);
    chk("rst_ram_we", ifa.ram_we, 0);
    chk("rst_if_ready", ifa.if_ready, 0);
    chk("rst_mem_ready", ifa.mem_ready, 0);
    chk("rst_ram_addr", ifa.ram_addr, 0);
    chk("rst_ram_wdata", ifa.ram_wdata, 0);
    chk("rst_if_rdata", ifa.if_rdata, 0);
    chk("rst_mem_rdata", ifa.mem_rdata, 0);
    rst = 1'b1;
    tick();

    // Fetch 0x0 on the RAM_LAT=2 instance: ready 3 cycles after request.
    ifa.if_req = 1; ifa.if_addr = 32'h0;
    #1 chk("f0_stall_c0", ifa.stall_if, 1);
    tick();
    chk("f0_en_c1", ifa.ram_en, 1);
    chk("f0_we_c1", ifa.ram_we, 0);
    chk("f0_rdy_c1", ifa.if_ready, 0);
    tick();
    chk("f0_en_c2", ifa.ram_en, 0);
    chk("f0_stall_c2", ifa.stall_if, 1);
    tick();
    chk("f0_rdy_c3", ifa.if_ready, 1);
    chk("f0_data_c3", ifa.if_rdata, 32'h0000_0013);
    chk("f0_stall_c3", ifa.stall_if, 0);
    ifa.if_req = 0;
    tick();
    chk("f0_rdy_c4", ifa.if_ready, 0);
    chk("f0_hold_c4", ifa.if_rdata, 32'h0000_0013);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if", pa_if, 3);
    chk("perf_mem", pa_mem, 0);
`endif

    // Load 0x40 -> 0x12345678.
    ifa.mem_read = 1; ifa.mem_addr = 32'h40;
    #1 chk("rd_stall_c0", ifa.stall_mem, 1);
    tick();
    chk("rd_en_c1", ifa.ram_en, 1);
    chk("rd_we_c1", ifa.ram_we, 0);
    chk("rd_addr_c1", ifa.ram_addr, 32'h40);
    chk("rd_stall_c1", ifa.stall_mem, 1);
    tick();
    chk("rd_en_c2", ifa.ram_en, 0);
    chk("rd_rdy_c2", ifa.mem_ready, 0);
    chk("rd_stall_c2", ifa.stall_mem, 1);
    tick();
    chk("rd_rdy_c3", ifa.mem_ready, 1);
    chk("rd_data_c3", ifa.mem_rdata, 32'h1234_5678);
    chk("rd_stall_c3", ifa.stall_mem, 0);
    chk("rd_ifhold", ifa.if_rdata, 32'h0000_0013);
    ifa.mem_read = 0;
    tick();
    chk("rd_rdy_c4", ifa.mem_ready, 0);

    // Store 0x44 <- 0xDEADBEEF: ready 2 cycles after request.
    ifa.mem_write = 1; ifa.mem_addr = 32'h44; ifa.mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_en_c1", ifa.ram_en, 1);
    chk("wr_we_c1", ifa.ram_we, 1);
    chk("wr_addr_c1", ifa.ram_addr, 32'h44);
    chk("wr_wdata_c1", ifa.ram_wdata, 32'hDEAD_BEEF);
    chk("wr_rdy_c1", ifa.mem_ready, 0);
    tick();
    chk("wr_rdy_c2", ifa.mem_ready, 1);
    chk("wr_en_c2", ifa.ram_en, 0);
    chk("wr_we_c2", ifa.ram_we, 0);
    chk("wr_wdata_hold", ifa.ram_wdata, 32'hDEAD_BEEF);
    chk("wr_rdata_hold", ifa.mem_rdata, 32'h1234_5678);
    ifa.mem_write = 0;
    tick();
    chk("wr_rdy_c3", ifa.mem_ready, 0);

    // Read and write together act as a write.
    ifa.mem_read = 1; ifa.mem_write = 1; ifa.mem_addr = 32'h4C; ifa.mem_wdata = 32'hCAFE_F00D;
    tick();
    chk("rw_we_c1", ifa.ram_we, 1);
    chk("rw_wdata_c1", ifa.ram_wdata, 32'hCAFE_F00D);
    tick();
    chk("rw_rdy_c2", ifa.mem_ready, 1);
    chk("rw_rdata_hold", ifa.mem_rdata, 32'h1234_5678);
    ifa.mem_read = 0; ifa.mem_write = 0;
    tick();

    // Fetch and load together: data first, fetch after an IDLE cycle.
    ifa.if_req = 1; ifa.if_addr = 32'h80; ifa.mem_read = 1; ifa.mem_addr = 32'h48;
    tick();
    chk("pr_addr_c1", ifa.ram_addr, 32'h48);
    chk("pr_stallif_c1", ifa.stall_if, 1);
    tick();
    chk("pr_stallif_c2", ifa.stall_if, 1);
    tick();
    chk("pr_mrdy_c3", ifa.mem_ready, 1);
    chk("pr_mdata_c3", ifa.mem_rdata, 32'h0048_C0DE);
    chk("pr_irdy_c3", ifa.if_ready, 0);
    chk("pr_stallif_c3", ifa.stall_if, 1);
    ifa.mem_read = 0;
    tick();
    chk("pr_en_c4", ifa.ram_en, 0);
    chk("pr_stallif_c4", ifa.stall_if, 1);
    tick();
    chk("pr_en_c5", ifa.ram_en, 1);
    chk("pr_addr_c5", ifa.ram_addr, 32'h80);
    chk("pr_stallif_c5", ifa.stall_if, 1);
    tick();
    chk("pr_irdy_c6", ifa.if_ready, 0);
    chk("pr_stallif_c6", ifa.stall_if, 1);
    tick();
    chk("pr_irdy_c7", ifa.if_ready, 1);
    chk("pr_idata_c7", ifa.if_rdata, 32'h0080_C0DE);
    ifa.if_req = 0;
    tick();

    // Request dropped after grant still completes.
    ifa.if_req = 1; ifa.if_addr = 32'h100;
    tick();
    chk("dr_en_c1", ifa.ram_en, 1);
    ifa.if_req = 0;
    tick();
    tick();
    chk("dr_rdy_c3", ifa.if_ready, 1);
    chk("dr_data_c3", ifa.if_rdata, 32'h0100_C0DE);
    tick();
    chk("dr_rdy_c4", ifa.if_ready, 0);

    // Reset asserted during WAIT abandons the load.
    ifa.mem_read = 1; ifa.mem_addr = 32'h40;
    tick();
    chk("rw8_en_c1", ifa.ram_en, 1);
    tick();
    rst = 1'b0; ifa.mem_read = 0;
    tick();
    chk("rwait_en", ifa.ram_en, 0);
    chk("rwait_mrdy", ifa.mem_ready, 0);
    chk("rwait_addr", ifa.ram_addr, 0);
    chk("rwait_mdata", ifa.mem_rdata, 0);
    chk("rwait_idata", ifa.if_rdata, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rwait_norpl", {31'd0, ifa.mem_ready}, 0);
    end

    // RAM_LAT=1 instance: fetch 0x0 ready 2 cycles after request.
    ifb.if_req = 1; ifb.if_addr = 32'h0;
    tick();
    chk("l1_en_c1", ifb.ram_en, 1);
    chk("l1_rdy_c1", ifb.if_ready, 0);
    tick();
    chk("l1_rdy_c2", ifb.if_ready, 1);
    chk("l1_data_c2", ifb.if_rdata, 32'h0000_0013);
    ifb.if_req = 0;
    tick();
    chk("l1_rdy_c3", ifb.if_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 2, means cycles from the ram_en cycle to valid ram_rdata; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset).
REQ-004 if_req  in  1  instruction fetch request, held until if_ready.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata, if_ready  out  32, 1  fetched word, one-cycle completion pulse.
REQ-007 mem_read, mem_write  in  1, 1  data access request from EX/MEM buffer, held until mem_ready.
REQ-008 mem_addr, mem_wdata  in  32, 32  data address (ALU result) and store data.
REQ-009 mem_rdata, mem_ready  out  32, 1  load data, one-cycle completion pulse.
REQ-010 stall_if, stall_mem  out  1, 1  pipeline stall to IF and MEM stages.
REQ-011 ram_en, ram_we  out  1, 1  shared single-port RAM enable and write enable.
REQ-012 ram_addr, ram_wdata  out  32, 32  RAM address and write data.
REQ-013 ram_rdata  in  32  RAM read data.

Function
REQ-014 FSM SHALL have states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-015 IDLE: on edge sampling a request, SHALL latch owner, address, wdata, op and go to ACCESS; otherwise stay.
REQ-016 Priority SHALL be fixed: data (mem_read|mem_write) over fetch when both sampled in IDLE.
REQ-017 mem_read and mem_write both high SHALL be treated as a write.
REQ-018 ACCESS: ram_en=1 exactly one cycle, ram_we=1 only for writes; ram_addr/ram_wdata SHALL hold latched values for the whole transaction.
REQ-019 Write: ACCESS SHALL go directly to DONE (request-to-ready 2 cycles).
REQ-020 Read: WAIT SHALL last RAM_LAT-1 cycles (0 for RAM_LAT=1), then ram_rdata captured into owner's rdata at the edge entering DONE (request-to-ready RAM_LAT+1 cycles).
REQ-021 DONE: owner's ready=1 for exactly one cycle, then IDLE; no grant SHALL be issued from DONE.
REQ-022 if_rdata/mem_rdata SHALL hold last captured value until next read by same owner.
REQ-023 stall_if = if_req & ~if_ready; stall_mem = (mem_read|mem_write) & ~mem_ready, combinational from registered ready.
REQ-024 Request deasserted mid-transaction: transaction SHALL still complete; ready pulse still issued.
REQ-025 New request arriving in ACCESS/WAIT/DONE SHALL wait for IDLE; no request SHALL be lost if held.

Reset
REQ-026 rst=0 at an edge SHALL force IDLE from any state, including mid-ACCESS/WAIT.
REQ-027 Reset values: ram_en, ram_we, if_ready, mem_ready = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0; wait counter = 0.
REQ-028 Transaction interrupted by reset SHALL be abandoned; no ready pulse after reset release.

Configuration
REQ-029 Macro MEM_ARB_PERF_CNT_EN defined: ports perf_if_stall, perf_mem_stall (out, 32) SHALL exist, incrementing each cycle stall_if / stall_mem is 1, wrapping 0xFFFFFFFF->0, cleared by reset.
REQ-030 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 RAM_LAT=2, mem_read=1 addr 0x40, RAM holds 0x12345678 -> ram_en one cycle, mem_ready 3 cycles after request edge, mem_rdata=0x12345678, stall_mem high until ready.
REQ-032 mem_write=1 addr 0x44 wdata 0xDEADBEEF -> ram_en=ram_we=1 one cycle with those values, mem_ready 2 cycles after request edge.
REQ-033 if_req and mem_read same cycle -> data served first, if_ready no earlier than one IDLE cycle after mem_ready; stall_if high throughout.
REQ-034 RAM_LAT=1 fetch addr 0x0 returning 0x00000013 -> if_ready 2 cycles after request edge, if_rdata=0x00000013.
REQ-035 rst=0 during WAIT -> next cycle IDLE, all outputs zero, no ready pulse after release.
REQ-036 MEM_ARB_PERF_CNT_EN: fetch stalled 3 cycles -> perf_if_stall=3; preload 0xFFFFFFFF plus one stall -> 0.
